uart_rx_core: RTL

Parametrised, self-contained UART receive core for the UART subsystem. It combines the receive controller, an oversampling edge/bit counter, a majority-vote sampler and the start/parity/stop checkers in one block. Data width, oversampling ratio and stop-bit count are set by parameters; parity enable and type are selected at run time. The deserialised word is delivered with a one-cycle `data_valid` pulse.

---
 rtl/uart_rx_core.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_rx_core.sv
// uart_rx_core: oversampling UART receiver with 2-of-3 majority sampling and parity/stop checks.
// Optional break detection (break_det output, BREAK state) is enabled by defining UART_RX_BREAK_DET_EN.
module uart_rx_core #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESCALE   = 16,
    parameter int STOP_BITS  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  Parity_Error,
    output logic                  Stop_Error,
`ifdef UART_RX_BREAK_DET_EN
    output logic                  break_det,
`endif
    output logic                  busy
);

    localparam int EW = $clog2(PRESCALE);
    localparam int BW = 4;

    localparam logic [EW-1:0] EDGE_LAST = EW'(PRESCALE - 1);
    localparam logic [EW-1:0] SMP_A     = EW'(PRESCALE / 2 - 1);
    localparam logic [EW-1:0] SMP_B     = EW'(PRESCALE / 2);
    localparam logic [EW-1:0] SMP_C     = EW'(PRESCALE / 2 + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_RX_BREAK_DET_EN
    localparam logic [2:0] S_BREAK  = 3'd5;
`endif

    logic                  rx_meta_q, rx_s_q;
    logic [2:0]            state_q, state_d;
    logic [EW-1:0]         edge_q, edge_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  s0_q, s0_d, s1_q, s1_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_en_q, par_en_d, par_typ_q, par_typ_d;
    logic                  par_bad_q, par_bad_d, stp_bad_q, stp_bad_d;
    logic [DATA_WIDTH-1:0] pdata_d;
    logic                  dv_d, pe_d, se_d;
    logic                  smp, at_sp, at_wrap, stop_bad;
    logic [BW-1:0]         last_stop;
`ifdef UART_RX_BREAK_DET_EN
    logic                  par_bit_q, par_bit_d, brk_d;
    logic [BW-1:0]         first_stop;
`endif

    assign smp       = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    assign at_sp     = (edge_q == SMP_C);
    assign at_wrap   = (edge_q == EDGE_LAST);
    assign last_stop = BW'(DATA_WIDTH + STOP_BITS) + BW'(par_en_q);
`ifdef UART_RX_BREAK_DET_EN
    assign first_stop = BW'(DATA_WIDTH + 1) + BW'(par_en_q);
`endif

    always_comb begin
        state_d   = state_q;
        edge_d    = edge_q;
        bit_d     = bit_q;
        s0_d      = s0_q;
        s1_d      = s1_q;
        shreg_d   = shreg_q;
        par_en_d  = par_en_q;
        par_typ_d = par_typ_q;
        par_bad_d = par_bad_q;
        stp_bad_d = stp_bad_q;
        pdata_d   = P_DATA;
        dv_d      = 1'b0;
        pe_d      = 1'b0;
        se_d      = 1'b0;
        stop_bad  = stp_bad_q | ~smp;
`ifdef UART_RX_BREAK_DET_EN
        par_bit_d = par_bit_q;
        brk_d     = 1'b0;
`endif
        if (state_q != S_IDLE) begin
            if (at_wrap) begin
                edge_d = '0;
                bit_d  = bit_q + 1'b1;
            end else begin
                edge_d = edge_q + 1'b1;
            end
            if (edge_q == SMP_A) s0_d = rx_s_q;
            if (edge_q == SMP_B) s1_d = rx_s_q;
        end
        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d   = S_START;
                    edge_d    = '0;
                    bit_d     = '0;
                    par_en_d  = PAR_EN;
                    par_typ_d = PAR_TYP;
                    par_bad_d = 1'b0;
                    stp_bad_d = 1'b0;
                end
            end
            S_START: begin
                if (at_sp && smp) state_d = S_IDLE;
                else if (at_wrap) state_d = S_DATA;
            end
            S_DATA: begin
                if (at_sp) shreg_d = {smp, shreg_q[DATA_WIDTH-1:1]};
                if (at_wrap && bit_q == BW'(DATA_WIDTH))
                    state_d = par_en_q ? S_PARITY : S_STOP;
            end
            S_PARITY: begin
                if (at_sp) begin
                    par_bad_d = ((^shreg_q) ^ par_typ_q) != smp;
`ifdef UART_RX_BREAK_DET_EN
                    par_bit_d = smp;
`endif
                end
                if (at_wrap) state_d = S_STOP;
            end
            S_STOP: begin
                if (at_sp) begin
                    stp_bad_d = stop_bad;
`ifdef UART_RX_BREAK_DET_EN
                    // A break is recognised at the first stop sample and overrides the error pulses.
                    if (bit_q == first_stop && shreg_q == '0 && !(par_en_q && par_bit_q) && !smp) begin
                        brk_d   = 1'b1;
                        state_d = S_BREAK;
                    end else
`endif
                    if (bit_q == last_stop) begin
                        state_d = S_IDLE;
                        if (par_bad_q || stop_bad) begin
                            pe_d = par_bad_q;
                            se_d = stop_bad;
                        end else begin
                            dv_d    = 1'b1;
                            pdata_d = shreg_q;
                        end
                    end
                end
            end
`ifdef UART_RX_BREAK_DET_EN
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rx_meta_q    <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            edge_q       <= '0;
            bit_q        <= '0;
            s0_q         <= 1'b0;
            s1_q         <= 1'b0;
            shreg_q      <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_bad_q    <= 1'b0;
            stp_bad_q    <= 1'b0;
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            Parity_Error <= 1'b0;
            Stop_Error   <= 1'b0;
            busy         <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q    <= 1'b0;
            break_det    <= 1'b0;
`endif
        end else begin
            rx_meta_q    <= RX_IN;
            rx_s_q       <= rx_meta_q;
            state_q      <= state_d;
            edge_q       <= edge_d;
            bit_q        <= bit_d;
            s0_q         <= s0_d;
            s1_q         <= s1_d;
            shreg_q      <= shreg_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_bad_q    <= par_bad_d;
            stp_bad_q    <= stp_bad_d;
            P_DATA       <= pdata_d;
            data_valid   <= dv_d;
            Parity_Error <= pe_d;
            Stop_Error   <= se_d;
            busy         <= (state_d != S_IDLE);
`ifdef UART_RX_BREAK_DET_EN
            par_bit_q    <= par_bit_d;
            break_det    <= brk_d;
`endif
        end
    end

endmodule
